sort_master_fsm: RTL and testbench



---
 rtl/sort_master_fsm_if.sv | 21 ++
 rtl/sort_master_fsm.sv | 101 ++++++++++
 tb/tb_sort_master_fsm.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sort_master_fsm_if.sv
// Control bundle between the sort controller and its 4x4-bit register-array datapath.
// master = controller side, slave = datapath / stimulus side.
interface sort_master_fsm_if;
  logic       START;
  logic [2:0] LT;
  logic [5:0] SEL;
  logic [3:0] LD;
  logic       BUSY;
  logic       DONE;
  logic [2:0] PASSES;

  modport master (
    input  START, LT,
    output SEL, LD, BUSY, DONE, PASSES
  );

  modport slave (
    output START, LT,
    input  SEL, LD, BUSY, DONE, PASSES
  );
endinterface

// File: rtl/sort_master_fsm.sv
// Bubble-sort controller for a 4-entry, 4-bit register array: load from SW, then one adjacent pair per clock.
// Result is descending (arr[0] largest); SEL/LD are Mealy on LT during the pass states.
module sort_master_fsm (
  input  logic              CLK,
  input  logic              CLR,
  sort_master_fsm_if.master bus
);

  typedef enum logic [2:0] {IDLE, LOAD, P0, P1, P2, DONE} state_t;

  state_t     state;
  logic       swapped;
  logic [2:0] pass_cnt;
  logic       busy_q;
  logic       done_q;
  logic [5:0] sel_c;
  logic [3:0] ld_c;
  logic       swap_now;

  // Mux selects and loads follow the current pair's less-than flag in the same cycle.
  always_comb begin
    sel_c    = 6'b000000;
    ld_c     = 4'b0000;
    swap_now = 1'b0;
    unique case (state)
      LOAD: ld_c = 4'b1111;
      P0: if (bus.LT[0]) begin
        swap_now = 1'b1;
        sel_c    = 6'b000011;
        ld_c     = 4'b0011;
      end
      P1: if (bus.LT[1]) begin
        swap_now = 1'b1;
        sel_c    = 6'b010100;
        ld_c     = 4'b0110;
      end
      P2: if (bus.LT[2]) begin
        swap_now = 1'b1;
        sel_c    = 6'b101000;
        ld_c     = 4'b1100;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state    <= IDLE;
      swapped  <= 1'b0;
      pass_cnt <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.START) begin
          state    <= LOAD;
          swapped  <= 1'b0;
          pass_cnt <= 3'd0;
          busy_q   <= 1'b1;
        end
        LOAD: state <= P0;
        P0: begin
          state <= P1;
          if (swap_now) swapped <= 1'b1;
        end
        P1: begin
          state <= P2;
          if (swap_now) swapped <= 1'b1;
        end
        P2: begin
          pass_cnt <= pass_cnt + 3'd1;
          // A swap in P2 itself still counts towards this pass needing a follow-up.
          if (!(swapped || swap_now) || pass_cnt == 3'd3) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state   <= P0;
            swapped <= 1'b0;
          end
        end
        DONE: if (!bus.START) begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SEL    = sel_c;
  assign bus.LD     = ld_c;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.PASSES = pass_cnt;

endmodule

// File: tb/tb_sort_master_fsm.sv
// Bench for sort_master_fsm: a register-array datapath model driven by SEL/LD, and a
// bubble-sort reference computed on plain arrays that predicts every cycle's SEL/LD.
module tb_sort_master_fsm;

  logic        CLK;
  logic        CLR;
  logic [15:0] sw;
  logic [3:0]  arr [4];
  int          total;
  int          passed;

  sort_master_fsm_if bus ();

  sort_master_fsm dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Datapath: four registers behind the M0..M3 muxes.
  always @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int k = 0; k < 4; k++) arr[k] <= 4'h0;
    end else begin
      if (bus.LD[0]) arr[0] <= bus.SEL[0] ? arr[1] : sw[3:0];
      if (bus.LD[1]) arr[1] <= (bus.SEL[2:1] == 2'b01) ? arr[0] :
                               (bus.SEL[2:1] == 2'b10) ? arr[2] : sw[7:4];
      if (bus.LD[2]) arr[2] <= (bus.SEL[4:3] == 2'b01) ? arr[3] :
                               (bus.SEL[4:3] == 2'b10) ? arr[1] : sw[11:8];
      if (bus.LD[3]) arr[3] <= bus.SEL[5] ? arr[2] : sw[15:12];
    end
  end

  assign bus.LT = {arr[2] < arr[3], arr[1] < arr[2], arr[0] < arr[1]};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One full sort from IDLE; every cycle's outputs are compared with the reference bubble sort.
  task automatic run_sort(input logic [15:0] val, input bit hold, input int exp_p);
    logic [3:0] ra [4];
    logic [3:0] t;
    logic [5:0] es;
    logic [3:0] el;
    bit         any;
    int         p;
    for (int k = 0; k < 4; k++) ra[k] = val[4*k +: 4];
    @(negedge CLK);
    sw        = val;
    bus.START = 1'b1;
    @(posedge CLK); #1;
    chk("load_ld", {12'h0, bus.LD}, 16'h000F);
    chk("load_sel", {10'h0, bus.SEL}, 16'h0000);
    chk("load_busy", {15'h0, bus.BUSY}, 16'h0001);
    chk("load_passes", {13'h0, bus.PASSES}, 16'h0000);
    @(negedge CLK);
    if (!hold) bus.START = 1'b0;
    p = 0;
    do begin
      any = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(posedge CLK); #1;
        es = 6'b000000;
        el = 4'b0000;
        if (ra[i] < ra[i+1]) begin
          es = (i == 0) ? 6'b000011 : (i == 1) ? 6'b010100 : 6'b101000;
          el = (i == 0) ? 4'b0011   : (i == 1) ? 4'b0110   : 4'b1100;
          t       = ra[i];
          ra[i]   = ra[i+1];
          ra[i+1] = t;
          any     = 1'b1;
        end
        chk($sformatf("pass%0d_p%0d_sel", p, i), {10'h0, bus.SEL}, {10'h0, es});
        chk($sformatf("pass%0d_p%0d_ld", p, i), {12'h0, bus.LD}, {12'h0, el});
        chk($sformatf("pass%0d_p%0d_busy", p, i), {15'h0, bus.BUSY}, 16'h0001);
        chk($sformatf("pass%0d_p%0d_done", p, i), {15'h0, bus.DONE}, 16'h0000);
      end
      p++;
    end while (any && p < 4);
    @(posedge CLK); #1;
    chk("done_flag", {15'h0, bus.DONE}, 16'h0001);
    chk("done_busy", {15'h0, bus.BUSY}, 16'h0000);
    chk("done_ld", {12'h0, bus.LD}, 16'h0000);
    chk("done_passes", {13'h0, bus.PASSES}, p[15:0]);
    if (exp_p >= 0) chk("spec_passes", {13'h0, bus.PASSES}, exp_p[15:0]);
    chk("sorted_arr", {arr[3], arr[2], arr[1], arr[0]}, {ra[3], ra[2], ra[1], ra[0]});
    if (!hold) begin
      @(posedge CLK); #1;
      chk("idle_done", {15'h0, bus.DONE}, 16'h0000);
      chk("idle_passes_hold", {13'h0, bus.PASSES}, p[15:0]);
    end
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    sw        = 16'h0000;
    bus.START = 1'b0;
    CLR       = 1'b0;
    #3 CLR = 1'b1;
    #2;
    chk("rst_sel", {10'h0, bus.SEL}, 16'h0000);
    chk("rst_ld", {12'h0, bus.LD}, 16'h0000);
    chk("rst_busy", {15'h0, bus.BUSY}, 16'h0000);
    chk("rst_done", {15'h0, bus.DONE}, 16'h0000);
    chk("rst_passes", {13'h0, bus.PASSES}, 16'h0000);
    @(negedge CLK);
    CLR = 1'b0;

    run_sort(16'h1234, 1'b0, 1);
    chk("arr_1234", {arr[3], arr[2], arr[1], arr[0]}, 16'h1234);
    run_sort(16'h4321, 1'b0, 4);
    chk("arr_4321", {arr[3], arr[2], arr[1], arr[0]}, 16'h1234);
    run_sort(16'h5555, 1'b0, 1);
    chk("arr_5555", {arr[3], arr[2], arr[1], arr[0]}, 16'h5555);
    run_sort(16'h2F07, 1'b0, 3);
    chk("arr_2f07", {arr[3], arr[2], arr[1], arr[0]}, 16'h027F);

    for (int n = 0; n < 8; n++) run_sort($urandom_range(16'hFFFF, 0), 1'b0, -1);

    // Reset during pass 2, P1 of the worst-case input.
    @(negedge CLK);
    sw        = 16'h4321;
    bus.START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("mid_p1_ld", {12'h0, bus.LD}, 16'h0006);
    CLR = 1'b1;
    #1;
    chk("clr_sel", {10'h0, bus.SEL}, 16'h0000);
    chk("clr_ld", {12'h0, bus.LD}, 16'h0000);
    chk("clr_busy", {15'h0, bus.BUSY}, 16'h0000);
    chk("clr_done", {15'h0, bus.DONE}, 16'h0000);
    chk("clr_passes", {13'h0, bus.PASSES}, 16'h0000);
    @(negedge CLK);
    CLR = 1'b0;
    run_sort(16'h4321, 1'b0, 4);

    // START held through DONE: no restart until it drops and rises again.
    run_sort(16'h3A1C, 1'b1, -1);
    for (int n = 0; n < 3; n++) begin
      @(posedge CLK); #1;
      chk("hold_done", {15'h0, bus.DONE}, 16'h0001);
      chk("hold_busy", {15'h0, bus.BUSY}, 16'h0000);
      chk("hold_ld", {12'h0, bus.LD}, 16'h0000);
    end
    @(negedge CLK);
    bus.START = 1'b0;
    @(posedge CLK); #1;
    chk("release_done", {15'h0, bus.DONE}, 16'h0000);
    chk("release_busy", {15'h0, bus.BUSY}, 16'h0000);
    run_sort(16'h9E06, 1'b0, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
